// File: rtl/buzzer_pattern_gen.sv
// Beep-pattern buzzer driver: programmable square-wave tone gated into ON/OFF
// beeps, with a repeat count or continuous mode, reporting busy/done upstream.
module buzzer_pattern_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int TONE_W  = 16,
  parameter int DUR_W   = 10,
  parameter int REP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TONE_W-1:0] half_period,
  input  logic [DUR_W-1:0]  on_len,
  input  logic [DUR_W-1:0]  off_len,
  input  logic [REP_W-1:0]  reps,
  output logic              busy,
  output logic              done,
  output logic              buzzer,
  output logic [1:0]        dbg_state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [DUR_W-1:0]    phase_q, phase_d;
  logic [REP_W-1:0]    beep_q, beep_d;
  logic [TONE_W-1:0]   hp_q, hp_d;
  logic [DUR_W-1:0]    on_q, on_d;
  logic [DUR_W-1:0]    off_q, off_d;
  logic [REP_W-1:0]    reps_q, reps_d;
  logic                buzz_q, buzz_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic [DUR_W-1:0]    len_m1;
  logic                phase_end;
  logic [REP_W-1:0]    beep_inc;

  // Request handshake: start is a one-cycle request that is accepted only
  // while busy is low (and stop is low); busy rises on the following cycle and
  // stays high until the pattern ends, where done pulses for finite patterns.

  assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
  assign len_m1    = (state_q == ST_ON) ? (on_q - DUR_W'(1)) : (off_q - DUR_W'(1));
  assign phase_end = tick && (phase_q == len_m1);
  // Saturates so continuous mode can run forever without wrapping back to reps.
  assign beep_inc  = (beep_q == {REP_W{1'b1}}) ? beep_q : (beep_q + REP_W'(1));

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : (pre_q + PRE_W'(1));
    tone_d  = tone_q;
    phase_d = tick ? (phase_q + DUR_W'(1)) : phase_q;
    beep_d  = beep_q;
    hp_d    = hp_q;
    on_d    = on_q;
    off_d   = off_q;
    reps_d  = reps_q;
    buzz_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pre_d   = '0;
        tone_d  = '0;
        phase_d = '0;
        if (start && !stop) begin
          state_d = ST_ON;
          beep_d  = REP_W'(1);
          hp_d    = half_period;
          on_d    = (on_len == '0) ? DUR_W'(1) : on_len;
          off_d   = off_len;
          reps_d  = reps;
        end
      end

      ST_ON: begin
        if (stop) begin
          state_d = ST_IDLE;
          pre_d   = '0;
          tone_d  = '0;
          phase_d = '0;
        end else if (phase_end) begin
          pre_d   = '0;
          tone_d  = '0;
          phase_d = '0;
          if ((reps_q != '0) && (beep_q == reps_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (off_q != '0) begin
            state_d = ST_OFF;
          end else begin
            // Back-to-back beeps: buzzer drops for one cycle as the tone restarts.
            state_d = ST_ON;
            beep_d  = beep_inc;
          end
        end else if (hp_q != '0) begin
          if (tone_q == (hp_q - TONE_W'(1))) begin
            tone_d = '0;
            buzz_d = ~buzz_q;
          end else begin
            tone_d = tone_q + TONE_W'(1);
            buzz_d = buzz_q;
          end
        end else begin
          tone_d = '0;
        end
      end

      ST_OFF: begin
        if (stop) begin
          state_d = ST_IDLE;
          pre_d   = '0;
          phase_d = '0;
        end else if (phase_end) begin
          state_d = ST_ON;
          pre_d   = '0;
          phase_d = '0;
          tone_d  = '0;
          beep_d  = beep_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
        tone_d  = '0;
        phase_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      tone_q  <= '0;
      phase_q <= '0;
      beep_q  <= '0;
      hp_q    <= '0;
      on_q    <= '0;
      off_q   <= '0;
      reps_q  <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
      beep_q  <= beep_d;
      hp_q    <= hp_d;
      on_q    <= on_d;
      off_q   <= off_d;
      reps_q  <= reps_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign buzzer    = buzz_q;
  assign dbg_state = state_q;

endmodule

// File: doc/buzzer_pattern_gen.md
Name: buzzer_pattern_gen

Overview:
Parametrised successor to the fixed 1 kHz buzzer driver. It generates a square-wave tone with a run-time programmable half-period. The tone is gated into a beep pattern: programmable ON and OFF durations in ticks, plus a repeat count or continuous mode. It sits between the alarm/UI control logic and the buzzer pin, and reports busy/done back to the controller.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 1000, duration time base; TICK_DIV = CLK_HZ/TICK_HZ clock cycles per tick (must be an integer >= 2)
TONE_W, 16, width of half_period
DUR_W, 10, width of on_len / off_len, in ticks
REP_W, 4, width of reps

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a pattern; honoured only in IDLE
stop  input  1  abort any running pattern
half_period  input  TONE_W  tone half-period in clk cycles; 0 = silent beeps
on_len  input  DUR_W  beep ON duration in ticks; 0 is treated as 1
off_len  input  DUR_W  gap between beeps in ticks; 0 = no gap
reps  input  REP_W  number of beeps; 0 = continuous until stop
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when a finite pattern completes normally
buzzer  output  1  tone output to the buzzer pin

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; buzzer=0, busy=0, done=0; all counters and latched config cleared. This applies in any state, including mid-beep.
- States: IDLE, ON, OFF.
- Config latch: half_period, on_len, off_len and reps are captured on the cycle start is accepted. Input changes while busy have no effect.
- IDLE -> ON: on start=1 and stop=0.
  - Next cycle: busy=1, buzzer=0, prescaler, tone and phase counters cleared, beep counter = 1.
  - start while busy is ignored.
  - start and stop in the same cycle in IDLE: stop wins; stays IDLE.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 when count==TICK_DIV-1. It is cleared on every phase entry, so a phase of N ticks lasts exactly N*TICK_DIV cycles.
- Tone (ON only), with half_period != 0:
  - tone counter counts 0..half_period-1.
  - At half_period-1 the buzzer toggles and the counter wraps.
  - The first rising edge of buzzer therefore occurs half_period cycles after ON entry; tone period = 2*half_period cycles.
  - half_period=0: buzzer held 0 for the whole ON phase (silent beep; timing unchanged).
- Phase counter: increments on tick. A phase ends on the tick where the counter reaches its length-1.
- ON end:
  - Finite pattern, beep counter == reps: -> IDLE. done=1 for exactly one cycle coincident with the IDLE entry. The trailing OFF is skipped.
  - Otherwise, off_len != 0: -> OFF.
  - Otherwise, off_len == 0: -> ON directly, beep counter +1, tone counter restarts and buzzer forced 0 for that cycle.
- OFF: buzzer=0. At end -> ON, beep counter +1.
- Continuous (reps=0): ON/OFF alternate indefinitely. The beep counter saturates and is not compared; done is never asserted.
- Beep counter has width REP_W and never wraps inside a finite pattern.
- stop=1 in ON or OFF: next cycle state=IDLE, buzzer=0, busy=0, done=0.
- buzzer is a registered output: no combinational path from any input.
- busy is registered and equals (state != IDLE).

Test Plan:
Use CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10) for all scenarios.
1. Single beep: half_period=2, on_len=3, off_len=5, reps=1, start pulse -> busy high for 30 cycles; buzzer toggles every 2 cycles (period 4, first rise 2 cycles after ON entry); then done=1 for one cycle, busy=0, buzzer=0; no OFF phase observed.
2. Three beeps: half_period=3, on_len=2, off_len=1, reps=3 -> ON 20 / OFF 10 / ON 20 / OFF 10 / ON 20 cycles, buzzer period 6 in ON and 0 in OFF; total busy 80 cycles; one done pulse.
3. Continuous mode and stop: reps=0, on_len=1, off_len=1, run 200 cycles -> 10 ON/OFF pairs, no done pulse. Assert stop mid-ON -> next cycle busy=0, buzzer=0, done=0.
4. Ignored start and latched config: start mid-pattern with a new half_period=7 -> pattern timing and tone unchanged. start+stop together in IDLE -> stays IDLE.
5. Reset mid-ON: rst high for 1 cycle -> all outputs 0 next cycle. A new start then begins a fresh pattern with beep counter = 1.
6. Edge values:
   - half_period=0, on_len=2, reps=1 -> buzzer stays 0, busy for 20 cycles, done pulses.
   - on_len=0 -> ON lasts 10 cycles.
   - off_len=0, reps=2 -> 20 consecutive ON cycles with buzzer forced 0 for 1 cycle at the beep boundary.
